// File: rtl/mem_stage_if.sv
// Bundle of EX-side, data-memory and write-back signals for the memory stage.
interface mem_stage_if #(
    parameter int unsigned ADDR_W = 12
);
    // From EX
    logic              ex_valid;
    logic [2:0]        ex_mem_op;
    logic [15:0]       alu_result;
    logic [15:0]       store_data;
    logic [15:0]       pc_plus1;
    logic [2:0]        flags_in;
    logic              int_req;
    logic [15:0]       int_ret_pc;
    // Data memory
    logic [15:0]       dmem_rdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic [15:0]       dmem_wdata;
    logic              dmem_we;
    logic              dmem_re;
    // Back to EX / write-back / fetch
    logic              stall;
    logic              wb_valid;
    logic [15:0]       wb_data;
    logic              pop_flags_valid;
    logic [2:0]        pop_flags;
    logic              pc_redirect;
    logic [15:0]       pc_target;
    logic              int_ack;
    logic [ADDR_W-1:0] sp;

    modport slave (
        input  ex_valid, ex_mem_op, alu_result, store_data, pc_plus1, flags_in,
               int_req, int_ret_pc, dmem_rdata,
        output dmem_addr, dmem_wdata, dmem_we, dmem_re, stall, wb_valid, wb_data,
               pop_flags_valid, pop_flags, pc_redirect, pc_target, int_ack, sp
    );

    modport master (
        output ex_valid, ex_mem_op, alu_result, store_data, pc_plus1, flags_in,
               int_req, int_ret_pc, dmem_rdata,
        input  dmem_addr, dmem_wdata, dmem_we, dmem_re, stall, wb_valid, wb_data,
               pop_flags_valid, pop_flags, pc_redirect, pc_target, int_ack, sp
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: data-memory port, stack pointer, RET/RTI redirects and the
// hardware interrupt save sequence (push PC, push flags, jump to INT_VEC).
module mem_stage #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned SP_INIT = 2**ADDR_W - 1,
    parameter logic [15:0] INT_VEC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpLoad  = 3'd1;
    localparam logic [2:0] OpStore = 3'd2;
    localparam logic [2:0] OpPush  = 3'd3;
    localparam logic [2:0] OpPop   = 3'd4;
    localparam logic [2:0] OpCall  = 3'd5;
    localparam logic [2:0] OpRet   = 3'd6;
    localparam logic [2:0] OpRti   = 3'd7;

    typedef enum logic [1:0] {StIdle, StRtiPop2, StRtiDone, StIntPush2} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              wb_valid_q;
    logic              ret_pend_q;
    logic [2:0]        saved_flags_q;

    logic              accept;
    logic              int_take;
    logic [ADDR_W-1:0] sp_p1, sp_m1;
    logic              unused_alu_hi;

    assign unused_alu_hi = ^bus.alu_result[15:ADDR_W];

    assign sp_p1    = sp_q + ADDR_W'(1);
    assign sp_m1    = sp_q - ADDR_W'(1);
    assign accept   = rst_n && (state_q == StIdle) && bus.ex_valid && (bus.ex_mem_op != OpNop);
    assign int_take = rst_n && (state_q == StIdle) && bus.int_req && !accept;

    // Combinational memory port, stall and next SP for the current cycle.
    always_comb begin
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_we    = 1'b0;
        bus.dmem_re    = 1'b0;
        bus.stall      = 1'b0;
        sp_d           = sp_q;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        unique case (bus.ex_mem_op)
                            OpLoad: begin
                                bus.dmem_addr = bus.alu_result[ADDR_W-1:0];
                                bus.dmem_re   = 1'b1;
                            end
                            OpStore: begin
                                bus.dmem_addr  = bus.alu_result[ADDR_W-1:0];
                                bus.dmem_we    = 1'b1;
                                bus.dmem_wdata = bus.store_data;
                            end
                            OpPush, OpCall: begin
                                bus.dmem_addr  = sp_q;
                                bus.dmem_we    = 1'b1;
                                bus.dmem_wdata = (bus.ex_mem_op == OpCall) ? bus.pc_plus1
                                                                           : bus.store_data;
                                sp_d           = sp_m1;
                            end
                            OpPop, OpRet, OpRti: begin
                                bus.dmem_addr = sp_p1;
                                bus.dmem_re   = 1'b1;
                                sp_d          = sp_p1;
                                bus.stall     = (bus.ex_mem_op == OpRti);
                            end
                            default: ;
                        endcase
                    end else if (int_take) begin
                        bus.dmem_addr  = sp_q;
                        bus.dmem_we    = 1'b1;
                        bus.dmem_wdata = bus.int_ret_pc;
                        sp_d           = sp_m1;
                        bus.stall      = 1'b1;
                    end
                end
                StRtiPop2: begin
                    bus.dmem_addr = sp_p1;
                    bus.dmem_re   = 1'b1;
                    sp_d          = sp_p1;
                    bus.stall     = 1'b1;
                end
                StIntPush2: begin
                    bus.dmem_addr  = sp_q;
                    bus.dmem_we    = 1'b1;
                    bus.dmem_wdata = {13'b0, bus.flags_in};
                    sp_d           = sp_m1;
                    bus.stall      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, stack pointer and result-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sp_q          <= ADDR_W'(SP_INIT);
            wb_valid_q    <= 1'b0;
            ret_pend_q    <= 1'b0;
            saved_flags_q <= '0;
        end else begin
            sp_q       <= sp_d;
            wb_valid_q <= accept && (bus.ex_mem_op == OpLoad || bus.ex_mem_op == OpPop);
            ret_pend_q <= accept && (bus.ex_mem_op == OpRet);
            unique case (state_q)
                StIdle: begin
                    if (accept && bus.ex_mem_op == OpRti) begin
                        state_q <= StRtiPop2;
                    end else if (int_take) begin
                        state_q <= StIntPush2;
                    end
                end
                StRtiPop2: begin
                    // Stack top holds the flags (pushed last on interrupt entry).
                    saved_flags_q <= bus.dmem_rdata[2:0];
                    state_q       <= StRtiDone;
                end
                StRtiDone:  state_q <= StIdle;
                StIntPush2: state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    // Result outputs derive from registered state; read data is forwarded as it arrives.
    always_comb begin
        bus.wb_valid        = wb_valid_q;
        bus.wb_data         = wb_valid_q ? bus.dmem_rdata : 16'h0000;
        bus.pop_flags_valid = (state_q == StRtiDone);
        bus.pop_flags       = (state_q == StRtiDone) ? saved_flags_q : 3'b000;
        bus.int_ack         = (state_q == StIntPush2);
        bus.pc_redirect     = ret_pend_q || (state_q == StRtiDone) || (state_q == StIntPush2);
        if (ret_pend_q || state_q == StRtiDone) begin
            bus.pc_target = bus.dmem_rdata;
        end else if (state_q == StIntPush2) begin
            bus.pc_target = INT_VEC;
        end else begin
            bus.pc_target = 16'h0000;
        end
        bus.sp = sp_q;
    end

endmodule
